// File: rtl/semaforo_completo.sv
// semaforo_completo: two-street traffic-light controller with a parade mode.
// A mode FSM (NORMAL/PARADE) drives the internal flag m. A lights FSM
// sequences the lamps of streets A and B. Both FSMs are Moore machines, and
// the lamps are decoded from the lights state only. While m is set, the
// lights FSM holds street B green in S2.
module semaforo_completo (
   input  logic       clk,
   input  logic       reset,
   input  logic       TA,
   input  logic       TB,
   input  logic       P,
   input  logic       R,
   output logic [2:0] LA,
   output logic [2:0] LB
);

   // Lamp encodings, one-hot {red, yellow, green}
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_RED    = 3'b100;

   typedef enum logic {
      NORMAL = 1'b0,
      PARADE = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      S0 = 2'd0,   // A green,  B red
      S1 = 2'd1,   // A yellow, B red
      S2 = 2'd2,   // A red,    B green
      S3 = 2'd3    // A red,    B yellow
   } light_t;

   // Snapshot of both FSM states for probes and checkers
   typedef struct packed {
      mode_t  mode;
      light_t light;
   } dbg_t;

   mode_t  mode_q, mode_d;
   light_t light_q, light_d;
   logic   m;
   dbg_t   dbg;

   // The lights FSM sees the registered mode, so a P/R request reaches the
   // lamps one edge after it is sampled
   assign m   = (mode_q == PARADE);
   assign dbg = '{mode: mode_q, light: light_q};

   // Mode state register; reset forces NORMAL
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q <= NORMAL;
      end else begin
         mode_q <= mode_d;
      end
   end

   // Mode next-state logic. R is ignored in NORMAL and P in PARADE, so
   // P and R together toggle the mode
   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         NORMAL:  if (P) mode_d = PARADE;
         PARADE:  if (R) mode_d = NORMAL;
         default: mode_d = NORMAL;
      endcase
   end

   // Lights state register; reset forces S0 regardless of the other inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         light_q <= S0;
      end else begin
         light_q <= light_d;
      end
   end

   // Lights next-state logic. TA is evaluated only in S0. TB and m are
   // evaluated only in S2
   always_comb begin
      light_d = S0;
      case (light_q)
         S0:      light_d = TA ? S0 : S1;
         S1:      light_d = S2;
         S2:      light_d = (m || TB) ? S2 : S3;
         S3:      light_d = S0;
         default: light_d = S0;
      endcase
   end

   // Moore lamp decode. Every state keeps at least one street red
   always_comb begin
      LA = LAMP_GREEN;
      LB = LAMP_RED;
      case (light_q)
         S0: begin
            LA = LAMP_GREEN;
            LB = LAMP_RED;
         end
         S1: begin
            LA = LAMP_YELLOW;
            LB = LAMP_RED;
         end
         S2: begin
            LA = LAMP_RED;
            LB = LAMP_GREEN;
         end
         S3: begin
            LA = LAMP_RED;
            LB = LAMP_YELLOW;
         end
         default: begin
            LA = LAMP_GREEN;
            LB = LAMP_RED;
         end
      endcase
   end

endmodule

// File: tb/tb_semaforo_completo.sv
// Testbench for semaforo_completo. A vector table of {inputs, expected
// lamps} is applied one clock per row. Hand-written sequences then cover
// the long parade hold and the P/R corner cases.
module tb_semaforo_completo;

   localparam logic [2:0] G  = 3'b001;
   localparam logic [2:0] Y  = 3'b010;
   localparam logic [2:0] RD = 3'b100;

   typedef struct {
      logic       rs;
      logic       ta;
      logic       tb;
      logic       p;
      logic       r;
      logic [2:0] la;
      logic [2:0] lb;
      string      name;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       reset;
   logic       TA;
   logic       TB;
   logic       P;
   logic       R;
   logic [2:0] LA;
   logic [2:0] LB;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   semaforo_completo dut (
      .clk   (clk),
      .reset (reset),
      .TA    (TA),
      .TB    (TB),
      .P     (P),
      .R     (R),
      .LA    (LA),
      .LB    (LB)
   );

   // ---------------- scoreboard ----------------
   logic [5:0] exp_q[$];
   int         checks;
   int         errors;
   vec_t       vecs[64];
   int         n_vecs;

   task automatic add(input logic rs, ta, tb, p, r,
                      input logic [2:0] la, lb, input string name);
      vecs[n_vecs].rs   = rs;
      vecs[n_vecs].ta   = ta;
      vecs[n_vecs].tb   = tb;
      vecs[n_vecs].p    = p;
      vecs[n_vecs].r    = r;
      vecs[n_vecs].la   = la;
      vecs[n_vecs].lb   = lb;
      vecs[n_vecs].name = name;
      n_vecs++;
   endtask

   // ---------------- driver ----------------
   // Drive on the falling edge, let one rising edge pass, then compare 1 ns
   // later against the expected lamps and the safety invariant
   task automatic step(input logic rs, ta, tb, p, r,
                       input logic [2:0] la, lb, input string name);
      logic [5:0] exp;
      @(negedge clk);
      reset = rs;
      TA    = ta;
      TB    = tb;
      P     = p;
      R     = r;
      exp_q.push_back({la, lb});
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({LA, LB} !== exp) begin
         errors++;
         $display("FAIL %s: got LA=%b LB=%b, expected LA=%b LB=%b",
                  name, LA, LB, exp[5:3], exp[2:0]);
      end
      checks++;
      if (!($onehot(LA) && $onehot(LB) && (LA == RD || LB == RD))) begin
         errors++;
         $display("FAIL %s_safety: got LA=%b LB=%b, expected one-hot lamps with one street red",
                  name, LA, LB);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks = 0;
      errors = 0;
      n_vecs = 0;
      reset  = 1'b1;
      TA     = 1'b0;
      TB     = 1'b0;
      P      = 1'b0;
      R      = 1'b0;

      // reset, then the free-running 4-clock cycle
      add(1, 0, 0, 0, 0, G,  RD, "reset");
      add(1, 1, 1, 1, 1, G,  RD, "reset_override");
      add(0, 0, 0, 0, 0, Y,  RD, "cyc_s1");
      add(0, 0, 0, 0, 0, RD, G,  "cyc_s2");
      add(0, 0, 0, 0, 0, RD, Y,  "cyc_s3");
      add(0, 0, 0, 0, 0, G,  RD, "cyc_s0");
      add(0, 0, 0, 0, 0, Y,  RD, "cyc2_s1");
      add(0, 0, 0, 0, 0, RD, G,  "cyc2_s2");
      add(0, 0, 0, 0, 0, RD, Y,  "cyc2_s3");
      add(0, 0, 0, 0, 0, G,  RD, "cyc2_s0");
      // TA holds S0 for 5 cycles, then S1 one edge after TA drops
      for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, G, RD, "ta_hold");
      add(0, 0, 0, 0, 0, Y,  RD, "ta_release");
      add(0, 0, 0, 0, 0, RD, G,  "ta_s2");
      // TB holds S2 for 4 cycles, then S3 and S0
      for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 0, RD, G, "tb_hold");
      add(0, 0, 0, 0, 0, RD, Y,  "tb_release");
      add(0, 0, 0, 0, 0, G,  RD, "tb_s0");
      // reset in S2 with P also set; the mode must stay NORMAL
      add(0, 0, 0, 0, 0, Y,  RD, "mid_s1");
      add(0, 0, 0, 0, 0, RD, G,  "mid_s2");
      add(1, 0, 1, 1, 0, G,  RD, "mid_reset");
      add(0, 0, 0, 0, 0, Y,  RD, "post_rst_s1");
      add(0, 0, 0, 0, 0, RD, G,  "post_rst_s2");
      add(0, 0, 0, 0, 0, RD, Y,  "post_rst_normal");
      add(0, 0, 0, 0, 0, G,  RD, "post_rst_s0");
      // R in NORMAL is ignored, so S2 still exits
      add(0, 0, 0, 0, 1, Y,  RD, "r_ignored_s1");
      add(0, 0, 0, 0, 0, RD, G,  "r_ignored_s2");
      add(0, 0, 0, 0, 0, RD, Y,  "r_ignored_s3");
      add(0, 0, 0, 0, 0, G,  RD, "r_ignored_s0");

      for (int i = 0; i < n_vecs; i++) begin
         step(vecs[i].rs, vecs[i].ta, vecs[i].tb, vecs[i].p, vecs[i].r,
              vecs[i].la, vecs[i].lb, vecs[i].name);
      end

      // parade: one-cycle P pulse in S0, then S2 holds with TB=0
      step(0, 0, 0, 1, 0, Y,  RD, "parade_s1");
      step(0, 0, 0, 0, 0, RD, G,  "parade_s2");
      for (int i = 0; i < 22; i++) step(0, 0, 0, 0, 0, RD, G, "parade_hold");
      // P is ignored in PARADE
      step(0, 0, 0, 1, 0, RD, G,  "parade_p_ignored");
      step(0, 0, 0, 0, 0, RD, G,  "parade_still");
      // R: mode clears on this edge, and S2 exits on the next one
      step(0, 0, 0, 0, 1, RD, G,  "return_edge");
      step(0, 0, 0, 0, 0, RD, Y,  "return_s3");
      step(0, 0, 0, 0, 0, G,  RD, "return_s0");

      // P=R=1 in NORMAL enters PARADE
      step(0, 0, 0, 1, 1, Y,  RD, "toggle_in_s1");
      step(0, 0, 0, 0, 0, RD, G,  "toggle_in_s2");
      step(0, 0, 0, 0, 0, RD, G,  "toggle_in_hold1");
      step(0, 0, 0, 0, 0, RD, G,  "toggle_in_hold2");
      // P=R=1 in PARADE returns to NORMAL
      step(0, 0, 0, 1, 1, RD, G,  "toggle_out_edge");
      step(0, 0, 0, 0, 0, RD, Y,  "toggle_out_s3");
      step(0, 0, 0, 0, 0, G,  RD, "toggle_out_s0");

      // reset while in PARADE returns to NORMAL
      step(0, 0, 0, 1, 0, Y,  RD, "prst_s1");
      step(0, 0, 0, 0, 0, RD, G,  "prst_s2");
      step(1, 0, 0, 0, 0, G,  RD, "prst_reset");
      step(0, 0, 0, 0, 0, Y,  RD, "prst_after_s1");
      step(0, 0, 0, 0, 0, RD, G,  "prst_after_s2");
      step(0, 0, 0, 0, 0, RD, Y,  "prst_after_normal");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
